peripheral_bus_master: RTL
==========================

# peripheral_bus_master

Initiator end of the internal peripheral bus. Accepts single Wishbone classic/pipelined accesses from the core interconnect and drives `peripheralEnable`, the 16-bit `peripheralBus_address` and the data strobes seen by every per-device address decoder. It then waits on the shared busy line and returns read data with an ack, or an error, to the Wishbone side. One instance sits between the Wishbone crossbar and all peripheral device slots.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles `peripheralBus_busy` may hold an access; only used when the timeout feature is compiled in; valid range 1..255.
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `wb_cyc_i`  in  1  Wishbone cycle
- `wb_stb_i`  in  1  Wishbone strobe
- `wb_we_i`  in  1  1 = write
- `wb_sel_i`  in  4  byte lane select
- `wb_adr_i`  in  24  byte address
- `wb_data_i`  in  32  write data
- `wb_ack_o`  out  1  access complete
- `wb_stall_o`  out  1  not accepting new request
- `wb_error_o`  out  1  access failed
- `wb_data_o`  out  32  read data
- `peripheralEnable`  out  1  access in progress, qualifies all bus outputs
- `peripheralBus_address`  out  16  device address; [15:12] device ID, [11:0] local address
- `peripheralBus_we`  out  1  write strobe
- `peripheralBus_oe`  out  1  read strobe
- `peripheralBus_byteSelect`  out  4  byte lanes
- `peripheralBus_dataWrite`  out  32  write data
- `peripheralBus_dataRead`  in  32  OR-combined read data from devices
- `peripheralBus_busy`  in  1  OR-combined; selected device not ready

## Operation
- States: IDLE, ACCESS, DONE, ERROR.
- IDLE: when `wb_cyc_i && wb_stb_i`, register we/sel/adr/data.
  - If `wb_adr_i[23:16] != 0`, go to ERROR with no peripheral access.
  - Otherwise go to ACCESS.
- ACCESS:
  - `peripheralEnable`=1, with `peripheralBus_we`=we and `peripheralBus_oe`=!we.
  - Address, byteSelect and dataWrite come from the registered values and are held stable for the whole state.
  - If `peripheralBus_busy`=0 this cycle: capture `peripheralBus_dataRead` into `wb_data_o` (reads only; writes leave it unchanged) and go to DONE.
  - If busy=1: stay in ACCESS.
- DONE: `wb_ack_o`=1 for exactly one cycle, then IDLE.
- ERROR: `wb_error_o`=1 for exactly one cycle, `wb_data_o`=32'hFFFF_FFFF, then IDLE.
- Abort: `wb_cyc_i` low while in ACCESS returns to IDLE on the next edge. No ack or error is issued, and all peripheral strobes drop that edge.
- `wb_stall_o` = (state != IDLE), combinational from state.
- Strobes (`peripheralEnable`, `_we`, `_oe`) are registered outputs, 0 outside ACCESS. Address, byteSelect and dataWrite keep their last value outside ACCESS.
- `wb_stb_i` seen in DONE or ERROR is ignored; stall is high there.
- Reset (`rst_n`=0 at an edge), from any state including mid-ACCESS:
  - state goes to IDLE
  - all outputs 0, except `wb_stall_o`=0
  - counter cleared
  - any in-flight access is dropped without ack.

## Timing
- Request sampled at edge N → `peripheralEnable` high from edge N+1.
- Zero-wait device (busy=0): data captured at edge N+2, `wb_ack_o` high N+2..N+3. Minimum latency is 2 cycles, at most one access per 3 cycles.
- Each busy cycle adds one cycle of latency.
- Bad-address request: `wb_error_o` high N+1..N+2; peripheral strobes never rise.
- `wb_ack_o` and `wb_error_o` are never high together, and each is at most one cycle wide per request.

## Configuration
- `PERIPHERAL_BUS_TIMEOUT_EN` defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle with busy=1.
  - When the count reaches `TIMEOUT_CYCLES` with busy still 1: drop the strobes and go to ERROR.
  - Error fires `TIMEOUT_CYCLES`+1 cycles after `peripheralEnable` rose.
  - busy falling on the same cycle the count reaches the limit: completes normally (DONE wins).
- Not defined: no counter; ACCESS waits on busy indefinitely; `TIMEOUT_CYCLES` unused.

## Test plan
- Write `wb_adr_i`=24'h003004, data 32'hDEADBEEF, sel 4'hF, busy=0:
  - address 16'h3004, we=1, enable high exactly 1 cycle
  - ack 2 cycles after request, no error.
- Read `wb_adr_i`=24'h001010, dataRead=32'h12345678, busy held high 3 cycles:
  - enable high 4 cycles
  - `wb_data_o`=32'h12345678 with ack at request+5.
- Request to `wb_adr_i`=24'h010000:
  - error pulse at N+1, `wb_data_o`=32'hFFFFFFFF
  - `peripheralEnable` never rises.
- With `PERIPHERAL_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, busy stuck high:
  - enable drops and error pulses 5 cycles after enable rose
  - no ack.
- Drop `wb_cyc_i` during busy wait: enable drops next edge, no ack or error, next request accepted normally.
- Assert `rst_n`=0 mid-ACCESS: next edge shows all strobes 0, stall 0, ack and error 0.

Source files
------------

// File: rtl/peripheral_bus_master.sv
// Wishbone-to-peripheral-bus initiator: one access at a time, busy-stretched, with bad-address error.
// Define PERIPHERAL_BUS_TIMEOUT_EN to abort accesses held busy for TIMEOUT_CYCLES.
module peripheral_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        wb_error_o,
  output logic [31:0] wb_data_o,
  output logic        peripheralEnable,
  output logic [15:0] peripheralBus_address,
  output logic        peripheralBus_we,
  output logic        peripheralBus_oe,
  output logic [3:0]  peripheralBus_byteSelect,
  output logic [31:0] peripheralBus_dataWrite,
  input  logic [31:0] peripheralBus_dataRead,
  input  logic        peripheralBus_busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_timeout_range_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_e;

  state_e      state_q, state_d;
  logic        req_we_q, req_we_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic        we_q, we_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic req_valid, adr_bad, accept, timed_out;

  assign req_valid = wb_cyc_i && wb_stb_i;
  assign adr_bad   = |wb_adr_i[23:16];
  assign accept    = (state_q == StIdle) && req_valid && !adr_bad;

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  // Counts busy cycles of the current access; idle outside ACCESS so entry starts at zero.
  always_comb begin
    cnt_d = 8'd0;
    if (state_q == StAccess && peripheralBus_busy) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timed_out = (cnt_q == TimeoutLimit);
`else
  assign timed_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats completion, completion beats timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = adr_bad ? StError : StAccess;
        end
      end
      StAccess: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (!peripheralBus_busy) begin
          state_d = StDone;
        end else if (timed_out) begin
          state_d = StError;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: registered outputs track the state being entered
  always_comb begin
    req_we_d = req_we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    if (accept) begin
      req_we_d = wb_we_i;
      addr_d   = wb_adr_i[15:0];
      sel_d    = wb_sel_i;
      wdata_d  = wb_data_i;
    end

    en_d  = (state_d == StAccess);
    we_d  = en_d && req_we_d;
    oe_d  = en_d && !req_we_d;
    ack_d = (state_d == StDone);
    err_d = (state_d == StError);

    rdata_d = rdata_q;
    if (state_q == StAccess && state_d == StDone && !req_we_q) begin
      rdata_d = peripheralBus_dataRead;
    end else if (state_d == StError) begin
      rdata_d = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_we_q <= 1'b0;
      addr_q   <= 16'd0;
      sel_q    <= 4'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      req_we_q <= req_we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign wb_stall_o               = (state_q != StIdle);
  assign wb_ack_o                 = ack_q;
  assign wb_error_o               = err_q;
  assign wb_data_o                = rdata_q;
  assign peripheralEnable         = en_q;
  assign peripheralBus_we         = we_q;
  assign peripheralBus_oe         = oe_q;
  assign peripheralBus_address    = addr_q;
  assign peripheralBus_byteSelect = sel_q;
  assign peripheralBus_dataWrite  = wdata_q;

endmodule
